// File: rtl/ide_buffer_loader.sv
// rtl/ide_buffer_loader.sv - sector fill engine and CPU-priority arbiter for the IDE buffer SRAM port
// Streams source bytes into the IDE data buffer, then arms iopos/iotarget/iocontrol.
module ide_buffer_loader #(
  parameter logic [3:0] IOCONTROL_REG = 4'h2,
  parameter logic [3:0] IOPOS_REG     = 4'h3,
  parameter logic [3:0] IOTARGET_REG  = 4'h5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] cpu_a,
  input  logic [7:0] cpu_d_in,
  output logic [7:0] cpu_d_out,
  input  logic       cpu_cs,
  input  logic       cpu_oe,
  input  logic       cpu_we,
  output logic       cpu_wait,
  output logic [9:0] ide_a,
  output logic [7:0] ide_d_out,
  input  logic [7:0] ide_d_in,
  output logic       ide_cs,
  output logic       ide_oe,
  output logic       ide_we,
  input  logic       ide_wait,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] len_words,
  input  logic [7:0] iocontrol_val,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREP    = 3'd1;
  localparam logic [2:0] S_FILL    = 3'd2;
  localparam logic [2:0] S_ARM_POS = 3'd3;
  localparam logic [2:0] S_ARM_TGT = 3'd4;
  localparam logic [2:0] S_ARM_CTL = 3'd5;

  logic [2:0] state;
  logic [8:0] byte_cnt;
  logic [7:0] len;
  logic [7:0] ctl_val;
  logic [9:0] eng_a;
  logic [7:0] eng_d;
  logic       eng_wr;
  logic       accept;
  logic       reg_state;

  always_comb begin
    eng_a = 10'h000;
    eng_d = 8'h00;
    case (state)
      S_PREP:    eng_a = {6'b0, IOCONTROL_REG};
      S_FILL:    begin eng_a = {1'b1, byte_cnt}; eng_d = src_data; end
      S_ARM_POS: eng_a = {6'b0, IOPOS_REG};
      S_ARM_TGT: begin eng_a = {6'b0, IOTARGET_REG}; eng_d = len; end
      S_ARM_CTL: begin eng_a = {6'b0, IOCONTROL_REG}; eng_d = ctl_val; end
      default:   eng_a = 10'h000;
    endcase
  end

  // Register writes retry every cycle until the CPU leaves the port; an abort drops the pending write.
  assign reg_state = (state == S_PREP) || (state == S_ARM_POS) ||
                     (state == S_ARM_TGT) || (state == S_ARM_CTL);
  assign src_ready = (state == S_FILL) && !cpu_cs;
  assign accept    = src_ready && src_valid;
  assign eng_wr    = !cpu_cs && !abort && (reg_state || ((state == S_FILL) && src_valid));
  assign done      = (state == S_ARM_CTL) && eng_wr;
  assign busy      = (state != S_IDLE);

  assign ide_a     = cpu_cs ? cpu_a    : eng_a;
  assign ide_d_out = cpu_cs ? cpu_d_in : eng_d;
  assign ide_cs    = cpu_cs ? 1'b1     : eng_wr;
  assign ide_oe    = cpu_cs ? cpu_oe   : 1'b0;
  assign ide_we    = cpu_cs ? cpu_we   : eng_wr;
  assign cpu_d_out = ide_d_in;
  assign cpu_wait  = cpu_cs && ide_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_cnt <= 9'd0;
      len      <= 8'h00;
      ctl_val  <= 8'h00;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          len      <= len_words;
          ctl_val  <= iocontrol_val;
          byte_cnt <= 9'd0;
          state    <= S_PREP;
        end
        S_PREP:    if (eng_wr) state <= S_FILL;
        S_FILL: if (accept) begin
          byte_cnt <= byte_cnt + 9'd1;
          if (byte_cnt == {len, 1'b1}) state <= S_ARM_POS;
        end
        S_ARM_POS: if (eng_wr) state <= S_ARM_TGT;
        S_ARM_TGT: if (eng_wr) state <= S_ARM_CTL;
        S_ARM_CTL: if (eng_wr) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ide_buffer_loader.sv
// tb/tb_ide_buffer_loader.sv - directed scoreboard bench for ide_buffer_loader
module tb_ide_buffer_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] cpu_a;
  logic [7:0] cpu_d_in, cpu_d_out;
  logic       cpu_cs, cpu_oe, cpu_we, cpu_wait;
  logic [9:0] ide_a;
  logic [7:0] ide_d_out, ide_d_in;
  logic       ide_cs, ide_oe, ide_we, ide_wait;
  logic [7:0] src_data;
  logic       src_valid, src_ready;
  logic       start, abort;
  logic [7:0] len_words, iocontrol_val;
  logic       busy, done;

  int vecs = 0;
  int errs = 0;
  logic [17:0] sb[$];

  ide_buffer_loader dut (
    .clk(clk), .rst(rst),
    .cpu_a(cpu_a), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out),
    .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_wait(cpu_wait),
    .ide_a(ide_a), .ide_d_out(ide_d_out), .ide_d_in(ide_d_in),
    .ide_cs(ide_cs), .ide_oe(ide_oe), .ide_we(ide_we), .ide_wait(ide_wait),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .start(start), .abort(abort), .len_words(len_words), .iocontrol_val(iocontrol_val),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: CPU pass-through checks, engine writes popped from the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_cs) begin
        chk("cpu_pass_a", {22'd0, ide_a}, {22'd0, cpu_a});
        chk("cpu_pass_d", {24'd0, ide_d_out}, {24'd0, cpu_d_in});
        chk("cpu_pass_strobes", {29'd0, ide_cs, ide_oe, ide_we}, {29'd0, 1'b1, cpu_oe, cpu_we});
        chk("cpu_src_ready", {31'd0, src_ready}, 32'd0);
        chk("cpu_wait", {31'd0, cpu_wait}, {31'd0, ide_wait});
      end else if (ide_cs) begin
        chk("eng_oe", {31'd0, ide_oe}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_write", {14'd0, ide_a, ide_d_out}, 32'hFFFFFFFF);
        end else begin
          chk("eng_write", {14'd0, ide_a, ide_d_out}, {14'd0, sb.pop_front()});
        end
      end
    end
  end

  // mode: 0 continuous, 1 CPU holds bus cyc 5..7, 2 src gaps + repeated start.
  // exp_done: >0 exact done cycle, 0 no done, -1 unused.
  task automatic do_load(input logic [7:0] len, input logic [7:0] ctl, input logic [7:0] base,
                         input logic [7:0] step, input int mode, input int abort_at,
                         input bit rst_tgt, input int exp_done);
    int n, nb, idx, ndone, done_clk;
    bit fin, acc, ab;
    logic [8:0] a9;
    n = 2 * (int'(len) + 1);
    nb = (abort_at >= 0) ? abort_at : n;
    sb.push_back({10'h002, 8'h00});
    for (int i = 0; i < nb; i++) begin
      a9 = i[8:0];
      sb.push_back({1'b1, a9, 8'(base + 8'(i) * step)});
    end
    if (abort_at < 0) begin
      sb.push_back({10'h003, 8'h00});
      if (!rst_tgt) begin
        sb.push_back({10'h005, len});
        sb.push_back({10'h002, ctl});
      end
    end
    len_words = len; iocontrol_val = ctl; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    len_words = 8'hEE; iocontrol_val = 8'hEE;
    idx = 0; ndone = 0; done_clk = 0; fin = 0;
    for (int cyc = 1; cyc <= 2000 && !fin; cyc++) begin
      src_valid = (idx < n) && (mode != 2 || (cyc % 2) == 0);
      src_data = 8'(base + 8'(idx) * step);
      if (mode == 1 && cyc >= 5 && cyc <= 7) begin
        cpu_cs = 1; cpu_we = 1; cpu_a = 10'h155; cpu_d_in = 8'hA5; ide_wait = 1;
      end else begin
        cpu_cs = 0; cpu_we = 0; cpu_a = 10'h000; cpu_d_in = 8'h00; ide_wait = 0;
      end
      if (mode == 2 && cyc == 3) start = 1'b1;
      ab = (abort_at >= 0) && (idx == abort_at) && src_valid;
      abort = ab;
      if (rst_tgt && cyc == n + 3) begin
        rst = 1'b1; #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_src_ready", {31'd0, src_ready}, 32'd0);
        chk("rst_strobes", {29'd0, ide_cs, ide_oe, ide_we}, 32'd0);
        @(negedge clk); rst = 1'b0;
        fin = 1;
      end else begin
        @(negedge clk);
        acc = src_valid && src_ready;
        if (done) begin ndone++; done_clk = cyc; end
        @(posedge clk); #1;
        start = 1'b0;
        if (acc) idx++;
        if (ab) begin
          abort = 1'b0;
          chk("abort_busy", {31'd0, busy}, 32'd0);
          fin = 1;
        end
        if (done_clk != 0) fin = 1;
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    src_valid = 0; cpu_cs = 0; cpu_we = 0; ide_wait = 0; abort = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("sb_empty", sb.size(), 32'd0);
    sb.delete();
    if (exp_done > 0) begin
      chk("done_clk", done_clk, exp_done);
      chk("done_count", ndone, 32'd1);
    end else begin
      chk("no_done", ndone, 32'd0);
    end
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cpu_a = 10'h000; cpu_d_in = 8'h00; cpu_cs = 0; cpu_oe = 0; cpu_we = 0;
    ide_d_in = 8'h3C; ide_wait = 0; src_data = 8'h00; src_valid = 0;
    start = 0; abort = 0; len_words = 8'h00; iocontrol_val = 8'h00;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_src_ready", {31'd0, src_ready}, 32'd0);
    chk("reset_strobes", {29'd0, ide_cs, ide_oe, ide_we}, 32'd0);
    chk("cpu_d_out", {24'd0, cpu_d_out}, 32'h3C);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    do_load(8'd0,   8'h02, 8'h11, 8'h11, 0, -1, 0, 6);
    do_load(8'd255, 8'h43, 8'h00, 8'h01, 0, -1, 0, 516);
    do_load(8'd3,   8'h81, 8'h40, 8'h03, 1, -1, 0, 15);
    do_load(8'd3,   8'h55, 8'h90, 8'h01, 0, 4,  0, 0);
    do_load(8'd0,   8'h66, 8'h20, 8'h01, 0, -1, 1, 0);
    do_load(8'd0,   8'h07, 8'hC0, 8'h05, 0, -1, 0, 6);
    do_load(8'd1,   8'h0A, 8'h70, 8'h01, 2, -1, 0, 11);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
